// File: rtl/icache_dm_param.sv
// Parametrised direct-mapped icache, critical-word-first refill via one memory port.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_dm_param #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              send_pulse,
    output logic [DATA_W-1:0] inst,
    output logic              ack,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_busy,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   data_q [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]    tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    logic [TAG_W-1:0]    f_tag;
    logic [IDX_W-1:0]    f_idx;
    logic [OFF_W-1:0]    f_word;
    logic [OFF_W-1:0]    f_cnt;
    logic                crit_pending;
    logic                flushed;
    logic                pend;
    logic [WA_W-1:0]     pend_addr;

    logic [WA_W-1:0]     lk_w;
    logic [OFF_W-1:0]    lk_off;
    logic [IDX_W-1:0]    lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic                lk_req;
    logic                lk_hit;
    logic                fill_done;
    logic                unused_bits;

    assign unused_bits = ^addr[1:0];

    // A held request takes priority; the requestor cannot send while one is held.
    assign lk_w   = pend ? pend_addr : addr[ADDR_W-1:2];
    assign lk_off = lk_w[OFF_W-1:0];
    assign lk_idx = lk_w[OFF_W+IDX_W-1:OFF_W];
    assign lk_tag = lk_w[WA_W-1:WA_W-TAG_W];
    assign lk_req = (state == IDLE) && (send_pulse || pend);
    assign lk_hit = lk_req && !flush && valid_q[lk_idx] &&
                    (tag_q[lk_idx] == lk_tag);

    assign mem_req   = (state == REQ) && !mem_busy;
    assign mem_addr  = mem_req ? {f_tag, f_idx, f_word, 2'b00} : '0;
    assign fill_done = (f_cnt == OFF_W'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (state == WAIT && mem_valid) begin
            data_q[f_idx][f_word] <= mem_rdata;
            if (fill_done) tag_q[f_idx] <= f_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ack          <= 1'b0;
            inst         <= '0;
            valid_q      <= '0;
            f_tag        <= '0;
            f_idx        <= '0;
            f_word       <= '0;
            f_cnt        <= '0;
            crit_pending <= 1'b0;
            flushed      <= 1'b0;
            pend         <= 1'b0;
            pend_addr    <= '0;
        end else begin
            ack <= 1'b0;
            if (state != IDLE && send_pulse) begin
                pend      <= 1'b1;
                pend_addr <= addr[ADDR_W-1:2];
            end
            case (state)
                IDLE: begin
                    if (lk_req) begin
                        pend <= 1'b0;
                        if (lk_hit) begin
                            ack  <= 1'b1;
                            inst <= data_q[lk_idx][lk_off];
                        end else begin
                            f_tag           <= lk_tag;
                            f_idx           <= lk_idx;
                            f_word          <= lk_off;
                            f_cnt           <= '0;
                            crit_pending    <= 1'b1;
                            flushed         <= 1'b0;
                            valid_q[lk_idx] <= 1'b0;
                            state           <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (!mem_busy) state <= WAIT;
                end
                WAIT: begin
                    if (mem_valid) begin
                        if (crit_pending) begin
                            ack          <= 1'b1;
                            inst         <= mem_rdata;
                            crit_pending <= 1'b0;
                        end
                        if (fill_done) begin
                            if (!flushed) valid_q[f_idx] <= 1'b1;
                            state <= IDLE;
                        end else begin
                            f_word <= f_word + OFF_W'(1);
                            f_cnt  <= f_cnt + OFF_W'(1);
                            state  <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Overrides any line being marked valid in this same cycle.
            if (flush) begin
                valid_q <= '0;
                if (state != IDLE) flushed <= 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (lk_req) begin
            if (lk_hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm_param.sv
// Directed bench for icache_dm_param with a latency-3 memory model.
// Expected instructions are queued on request and popped on ack.
module tb_icache_dm_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        send_pulse;
    logic [31:0] inst;
    logic        ack;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_busy;
    logic        mem_valid;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_dm_param dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .send_pulse (send_pulse),
        .inst       (inst),
        .ack        (ack),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_busy   (mem_busy),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] req_q[$];
    int          req_cyc_q[$];
    int          vld_cyc_q[$];

    function automatic logic [31:0] mv(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    // Memory: accepts a request seen at a negedge, returns data 3 edges later.
    initial begin
        int          cd;
        logic [31:0] ma;
        cd = -1;
        ma = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (cd > 0) cd--;
            if (cd == 0) begin
                mem_valid = 1'b1;
                mem_rdata = mv(ma);
                vld_cyc_q.push_back(cyc + 1);
                cd = -1;
            end
            if (mem_req) begin
                ma = mem_addr;
                cd = 3;
                req_q.push_back(mem_addr);
                req_cyc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        addr       = a;
        send_pulse = 1'b1;
        exp_q.push_back(mv(a & 32'hFFFF_FFFC));
        tick();
        send_pulse = 1'b0;
    endtask

    task automatic wait_ack(input string tag, output int c);
        int n;
        n = 0;
        while (!ack && n < 60) begin
            tick();
            n++;
        end
        if (!ack) begin
            chk({tag, "_timeout"}, 32'(ack), 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            c = -1;
        end else begin
            chk(tag, inst, exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD);
            c = cyc;
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] a);
        int c;
        issue(a);
        wait_ack(tag, c);
        repeat (24) tick();
    endtask

    task automatic clr();
        req_q.delete();
        req_cyc_q.delete();
        vld_cyc_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] seq [4];
        int c;
        int t0;
        seq[0] = 32'h108; seq[1] = 32'h10C;
        seq[2] = 32'h100; seq[3] = 32'h104;

        rst = 1'b1; addr = '0; send_pulse = 1'b0;
        flush = 1'b0; mem_busy = 1'b0;
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_mreq", 32'(mem_req), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // cold miss, critical word first with wrap
        clr();
        issue(32'h108);
        wait_ack("cold", c);
        chk("cold_lat", 32'(c), 32'(vld_cyc_q.size() > 0 ? vld_cyc_q[0] : -5));
        repeat (24) tick();
        chk("cold_nreq", 32'(req_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cold_addr%0d", i),
                req_q.size() > i ? req_q[i] : 32'hX, seq[i]);

        // hit on the same line
        clr();
        t0 = cyc;
        issue(32'h100);
        wait_ack("hit", c);
        chk("hit_lat", 32'(c - t0), 32'd1);
        chk("hit_noreq", 32'(req_q.size()), 32'd0);

        // flush in idle, then a request held during the fill is replayed
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clr();
        issue(32'h108);
        wait_ack("pend_crit", c);
        issue(32'h10C);
        wait_ack("pend", c);
        chk("pend_lat", 32'(c),
            32'(vld_cyc_q.size() > 3 ? vld_cyc_q[3] + 1 : -5));
        repeat (24) tick();
        chk("pend_nreq", 32'(req_q.size()), 32'd4);

        // conflict misses on index 0
        clr();
        fetch("cf_a", 32'h000);
        chk("cf_a_req", req_q.size() > 0 ? req_q[0] : 32'hX, 32'h000);
        clr();
        fetch("cf_b", 32'h400);
        chk("cf_b_nreq", 32'(req_q.size()), 32'd4);
        chk("cf_b_req", req_q.size() > 0 ? req_q[0] : 32'hX, 32'h400);
        clr();
        fetch("cf_c", 32'h000);
        chk("cf_c_nreq", 32'(req_q.size()), 32'd4);

        // memory busy stalls the request
        clr();
        mem_busy = 1'b1;
        issue(32'h608);
        repeat (4) tick();
        chk("busy_mreq0", 32'(mem_req), 32'd0);
        chk("busy_noreq", 32'(req_q.size()), 32'd0);
        t0 = cyc;
        mem_busy = 1'b0;
        #1;
        chk("busy_mreq1", 32'(mem_req), 32'd1);
        chk("busy_maddr", mem_addr, 32'h608);
        wait_ack("busy", c);
        chk("busy_reqcyc",
            32'(req_cyc_q.size() > 0 ? req_cyc_q[0] : -5), 32'(t0 + 1));
        repeat (24) tick();

        // flush during a fill
        clr();
        issue(32'h200);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ack("fl_crit", c);
        repeat (24) tick();
        clr();
        fetch("fl_next", 32'h204);
        chk("fl_next_nreq", 32'(req_q.size()), 32'd4);
        chk("fl_next_req", req_q.size() > 0 ? req_q[0] : 32'hX, 32'h204);

        // flush in idle, then flush together with a request
        fetch("fi_fill", 32'h300);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clr();
        fetch("fi_miss", 32'h300);
        chk("fi_miss_nreq", 32'(req_q.size()), 32'd4);
        clr();
        flush = 1'b1;
        issue(32'h300);
        flush = 1'b0;
        wait_ack("fs_miss", c);
        repeat (24) tick();
        chk("fs_nreq", 32'(req_q.size()), 32'd4);

        // reset while waiting on memory
        fetch("rs_fill", 32'h108);
        addr = 32'h500;
        send_pulse = 1'b1;
        tick();
        send_pulse = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rs_ack", 32'(ack), 32'd0);
        chk("rs_mreq", 32'(mem_req), 32'd0);
        rst = 1'b0;
        repeat (8) tick();
        clr();
        fetch("rs_miss", 32'h108);
        chk("rs_nreq", 32'(req_q.size()), 32'd4);
        chk("rs_req", req_q.size() > 0 ? req_q[0] : 32'hX, 32'h108);
`ifdef ICACHE_STATS_EN
        chk("rs_hits", hit_count, 32'd0);
        chk("rs_miss_cnt", miss_count, 32'd1);
`endif
        chk("exp_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
